traffic_mc_core: RTL and testbench

//  Parametrised multi-channel packet traffic generator. Successor of the two-channel UL/DL generator.
//  One LFSR per channel. Packets are issued in bursts once per programmable interval. Enabled channels
//  are served round-robin. Output is a valid/ready stream with drop accounting under backpressure.

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/traffic_mc_core_if.sv | 14 +
 rtl/traffic_lfsr.sv | 43 ++++
 rtl/traffic_mc_core.sv | 160 ++++++++++++++++
 tb/tb_traffic_mc_core.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the multi-channel traffic generator:
// LFSR polynomials, recovery seeds and the burst FSM state type.
package traffic_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } traffic_state_e;

   // Fibonacci tap masks: x^8+x^6+x^5+x^4 and x^16+x^15+x^13+x^4
   localparam logic [7:0]  TAPS_8   = 8'hB8;
   localparam logic [15:0] TAPS_16  = 16'hD008;
   localparam logic [7:0]  SEED_MIX = 8'h1D;

   function automatic logic [7:0] base_seed(input logic [1:0] sel);
      logic [7:0] s;
      case (sel)
         2'd0:    s = 8'hA5;
         2'd1:    s = 8'h3C;
         2'd2:    s = 8'h5E;
         2'd3:    s = 8'hC7;
         default: s = 8'hA5;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] chan_seed(input logic [1:0] sel, input logic [2:0] k);
      logic [7:0] mix;
      mix = base_seed(sel) ^ (8'(k) * SEED_MIX);
      return (mix == 8'h00) ? 8'h01 : mix;
   endfunction

   // Operates on a 16-bit container; narrow LFSRs live in the low byte.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic wide);
      logic [15:0] taps;
      logic        fb;
      taps = wide ? TAPS_16 : {8'h00, TAPS_8};
      fb   = ^(v & taps);
      return wide ? {v[14:0], fb} : {8'h00, v[6:0], fb};
   endfunction

endpackage

// File: rtl/traffic_mc_core_if.sv
// Packet stream towards the sink: valid/ready handshake plus drop accounting.
interface traffic_mc_core_if #(
   parameter int ID_W = 8,
   parameter int CH_W = 2
);
   logic            o_valid;
   logic            i_ready;
   logic [ID_W-1:0] o_packet_id;
   logic [CH_W-1:0] o_ch;
   logic [7:0]      o_drop_cnt;

   modport master (output o_valid, o_packet_id, o_ch, o_drop_cnt, input i_ready);
   modport slave  (input o_valid, o_packet_id, o_ch, o_drop_cnt, output i_ready);
endinterface

// File: rtl/traffic_lfsr.sv
// Per-channel packet-id LFSR with zero-lockup recovery; step_value is the
// post-step value presented combinationally so it can be issued this cycle.
module traffic_lfsr
   import traffic_pkg::*;
#(
   parameter int              ID_W    = 8,
   parameter logic [ID_W-1:0] RST_VAL = {{(ID_W-1){1'b0}}, 1'b1}
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            step,
   input  logic            reload,
   input  logic [ID_W-1:0] seed,
   output logic [ID_W-1:0] value,
   output logic [ID_W-1:0] step_value
);

   logic [ID_W-1:0] value_r;
   logic [ID_W-1:0] base_s;

   // Recovery seed replaces a locked-up value before any step is applied
   always_comb begin
      base_s     = reload ? seed : value_r;
      step_value = ID_W'(lfsr_step(16'(base_s), ID_W == 16));
   end

   // LFSR state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r <= RST_VAL;
      end else if (ena) begin
         if (step) begin
            value_r <= step_value;
         end else begin
            value_r <= base_s;
         end
      end
   end

   assign value = value_r;

endmodule

// File: rtl/traffic_mc_core.sv
// Multi-channel traffic generator: interval timer, burst FSM, round-robin
// channel arbiter and a registered valid/ready output stage with drop counting.
module traffic_mc_core
   import traffic_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ID_W   = 8,
   parameter int PER_W  = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] i_ch_en,
   input  logic [PER_W-1:0]  i_cfg_period,
   input  logic [1:0]        i_burst_len,
   input  logic [1:0]        i_seed_sel,
   traffic_mc_core_if.master bus
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = PER_W + 8;

   traffic_state_e  state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s, reload_s;
   logic [1:0]       rem_r, rem_nxt_s;
   logic [CH_W-1:0]  rr_r, rr_nxt_s, grant_s, ch_r;
   logic             found_s, slot_free_s, load_s, drop_s;
   logic             valid_r;
   logic [ID_W-1:0]  id_r, pkt_id_s;
   logic [7:0]       drop_r;
   logic [NUM_CH-1:0] step_s;
   logic [ID_W-1:0]  lfsr_s     [NUM_CH];
   logic [ID_W-1:0]  step_val_s [NUM_CH];

   assign reload_s    = {i_cfg_period, 8'hFF};
   assign slot_free_s = !valid_r || bus.i_ready;
   assign pkt_id_s    = step_val_s[grant_s];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lfsr
      logic [ID_W-1:0] seed_s;
      assign seed_s    = ID_W'(chan_seed(i_seed_sel, 3'(k)));
      assign step_s[k] = load_s && (grant_s == CH_W'(k));

      traffic_lfsr #(
         .ID_W    (ID_W),
         .RST_VAL (ID_W'(1) << (k % ID_W))
      ) u_lfsr (
         .clk        (clk),
         .rst_n      (rst_n),
         .ena        (ena),
         .step       (step_s[k]),
         .reload     (lfsr_s[k] == {ID_W{1'b0}}),
         .seed       (seed_s),
         .value      (lfsr_s[k]),
         .step_value (step_val_s[k])
      );
   end

   // Round-robin search: first enabled channel at or after the pointer, wrapping
   always_comb begin : p_arb
      logic [CH_W:0]   sum_v;
      logic [CH_W-1:0] idx_v;
      logic            hit_v;
      grant_s = {CH_W{1'b0}};
      found_s = 1'b0;
      sum_v   = {(CH_W+1){1'b0}};
      idx_v   = {CH_W{1'b0}};
      hit_v   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_v   = {1'b0, rr_r} + (CH_W+1)'(i);
         idx_v   = (sum_v >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum_v - (CH_W+1)'(NUM_CH))
                                                : CH_W'(sum_v);
         hit_v   = !found_s && i_ch_en[idx_v];
         grant_s = hit_v ? idx_v : grant_s;
         found_s = found_s || hit_v;
      end
   end

   // Interval/burst FSM: next state, counters and per-slot load/drop decision
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rem_nxt_s   = rem_r;
      rr_nxt_s    = rr_r;
      load_s      = 1'b0;
      drop_s      = 1'b0;
      if (i_ch_en == {NUM_CH{1'b0}}) begin
         cnt_nxt_s   = reload_s;
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cnt_r != {CNT_W{1'b0}}) begin
                  cnt_nxt_s = cnt_r - CNT_W'(1);
               end else begin
                  cnt_nxt_s   = reload_s;
                  rem_nxt_s   = i_burst_len;
                  state_nxt_s = ST_BURST;
               end
            end
            ST_BURST: begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
               rr_nxt_s  = (grant_s == CH_W'(NUM_CH-1)) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
               load_s    = found_s && slot_free_s;
               drop_s    = found_s && !slot_free_s;
               if (rem_r == 2'd0) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  rem_nxt_s = rem_r - 2'd1;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else if (ena) begin
         state_r <= state_nxt_s;
      end
   end

   // Counters, arbiter pointer and output stage; ena=0 freezes all of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CNT_W{1'b0}};
         rem_r   <= 2'd0;
         rr_r    <= {CH_W{1'b0}};
         valid_r <= 1'b0;
         id_r    <= {ID_W{1'b0}};
         ch_r    <= {CH_W{1'b0}};
         drop_r  <= 8'd0;
      end else if (ena) begin
         cnt_r <= cnt_nxt_s;
         rem_r <= rem_nxt_s;
         rr_r  <= rr_nxt_s;
         if (load_s) begin
            valid_r <= 1'b1;
            id_r    <= pkt_id_s;
            ch_r    <= grant_s;
         end else if (bus.i_ready) begin
            valid_r <= 1'b0;
         end
         if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
         end
      end
   end

   assign bus.o_valid     = valid_r;
   assign bus.o_packet_id = id_r;
   assign bus.o_ch        = ch_r;
   assign bus.o_drop_cnt  = drop_r;

endmodule

// File: tb/tb_traffic_mc_core.sv
// Directed bench for traffic_mc_core: a spec-level model predicts each packet
// into a scoreboard queue that is drained as the sink accepts packets.
`timescale 1ns/1ps
module tb_traffic_mc_core;
   import traffic_pkg::*;

   localparam int NUM_CH = 4;
   localparam int ID_W   = 8;
   localparam int PER_W  = 4;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ena;
   logic [NUM_CH-1:0] ch_en;
   logic [PER_W-1:0]  period;
   logic [1:0]        burst;
   logic [1:0]        seed_sel;

   traffic_mc_core_if #(.ID_W(ID_W), .CH_W(CH_W)) bus ();

   traffic_mc_core #(.NUM_CH(NUM_CH), .ID_W(ID_W), .PER_W(PER_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .i_ch_en      (ch_en),
      .i_cfg_period (period),
      .i_burst_len  (burst),
      .i_seed_sel   (seed_sel),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   int         n_acc       = 0;
   int         last_acc    = 0;
   int         prev_acc    = 0;
   int         c0          = 0;
   int         n_mark      = 0;
   logic [9:0] exp_q [$];
   logic [9:0] last_pkt;
   logic [7:0] m_lfsr [NUM_CH];
   int         m_rr;

   function automatic logic [7:0] m_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) m_lfsr[k] = 8'(1 << k);
      m_rr = 0;
      exp_q.delete();
   endtask

   // One burst slot of the reference: arbitrate, then issue (free) or drop
   task automatic model_slot(input logic [NUM_CH-1:0] mask, input bit free);
      int g;
      g = -1;
      for (int i = 0; i < NUM_CH; i++) begin
         int idx;
         idx = (m_rr + i) % NUM_CH;
         if (g < 0 && mask[idx]) g = idx;
      end
      m_rr = (g + 1) % NUM_CH;
      if (free) begin
         m_lfsr[g] = m_step(m_lfsr[g]);
         exp_q.push_back({2'(g), m_lfsr[g]});
      end
   endtask

   // Handshake that completes at the coming edge is scored, then one clock passes
   task automatic tick();
      if (ena && rst_n && bus.o_valid && bus.i_ready) begin
         n_acc++;
         prev_acc = last_acc;
         last_acc = cyc;
         check("pkt_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            last_pkt = exp_q.pop_front();
            check("pkt_ch", 32'(bus.o_ch), 32'(last_pkt[9:8]));
            check("pkt_id", 32'(bus.o_packet_id), 32'(last_pkt[7:0]));
            check("pkt_id_nonzero", 32'(bus.o_packet_id != 8'h00), 32'd1);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_acc(input int target, input int budget, input string tag);
      int b;
      b = budget;
      while (n_acc < target && b > 0) begin
         tick();
         b--;
      end
      check(tag, 32'(n_acc >= target), 32'd1);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int b;
      b = budget;
      while (!bus.o_valid && b > 0) begin
         tick();
         b--;
      end
      check(tag, 32'(bus.o_valid), 32'd1);
   endtask

   task automatic check_lfsrs(input string tag);
      for (int k = 0; k < NUM_CH; k++) check(tag, 32'(dut.lfsr_s[k]), 32'(m_lfsr[k]));
   endtask

   initial begin
      rst_n       = 1'b0;
      ena         = 1'b0;
      ch_en       = 4'b0000;
      period      = 4'd0;
      burst       = 2'd0;
      seed_sel    = 2'd0;
      bus.i_ready = 1'b1;
      model_reset();
      repeat (3) tick();

      // Reset values
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_id", 32'(bus.o_packet_id), 32'd0);
      check("rst_ch", 32'(bus.o_ch), 32'd0);
      check("rst_drop", 32'(bus.o_drop_cnt), 32'd0);
      check_lfsrs("rst_lfsr");
      rst_n = 1'b1;
      tick();

      // Two channels, single-packet bursts every 256 cycles
      ena   = 1'b1;
      ch_en = 4'b0011;
      for (int p = 0; p < 4; p++) model_slot(4'b0011, 1'b1);
      c0 = cyc;
      for (int p = 0; p < 4; p++) begin
         wait_acc(n_acc + 1, 400, "interval_pkt_timeout");
         if (p == 0) check("first_latency", 32'(last_acc - c0), 32'd2);
         else        check("interval_spacing", 32'(last_acc - prev_acc), 32'd256);
      end
      ch_en = 4'b0000;
      tick();

      // Burst of four on mask 0101, back-to-back
      ch_en = 4'b0101;
      burst = 2'd3;
      for (int p = 0; p < 4; p++) model_slot(4'b0101, 1'b1);
      for (int p = 0; p < 4; p++) begin
         wait_acc(n_acc + 1, 300, "burst_pkt_timeout");
         if (p > 0) check("burst_b2b", 32'(last_acc - prev_acc), 32'd1);
      end
      check("burst_drop", 32'(bus.o_drop_cnt), 32'd0);
      ch_en = 4'b0000;
      tick();

      // Whole burst under backpressure: first packet held, three drops
      bus.i_ready = 1'b0;
      ch_en       = 4'b0101;
      model_slot(4'b0101, 1'b1);
      for (int p = 0; p < 3; p++) model_slot(4'b0101, 1'b0);
      wait_valid(300, "bp_valid_timeout");
      for (int t = 0; t < 6; t++) begin
         check("bp_hold_valid", 32'(bus.o_valid), 32'd1);
         check("bp_hold_id", 32'(bus.o_packet_id), 32'(exp_q[0][7:0]));
         check("bp_hold_ch", 32'(bus.o_ch), 32'(exp_q[0][9:8]));
         tick();
      end
      check("bp_drop_cnt", 32'(bus.o_drop_cnt), 32'd3);
      check_lfsrs("bp_lfsr");
      bus.i_ready = 1'b1;
      wait_acc(n_acc + 1, 5, "bp_release_timeout");
      ch_en = 4'b0000;
      tick();

      // Zero-lockup recovery on channel 1 with seed_sel=01
      ena      = 1'b0;
      seed_sel = 2'd1;
      tick();
      force dut.g_lfsr[1].u_lfsr.value_r = 8'h00;
      tick();
      release dut.g_lfsr[1].u_lfsr.value_r;
      tick();
      check("lfsr_forced_zero", 32'(dut.lfsr_s[1]), 32'd0);
      ena = 1'b1;
      tick();
      check("lfsr_zero_reload", 32'(dut.lfsr_s[1]), 32'h21);
      m_lfsr[1] = 8'h21;
      ch_en = 4'b0010;
      burst = 2'd0;
      model_slot(4'b0010, 1'b1);
      wait_acc(n_acc + 1, 300, "reseed_pkt_timeout");
      ch_en = 4'b0000;
      tick();

      // Freeze with ena=0 in the middle of a burst, then resume
      ch_en = 4'b0101;
      burst = 2'd3;
      for (int p = 0; p < 4; p++) model_slot(4'b0101, 1'b1);
      n_mark = n_acc;
      wait_acc(n_acc + 1, 300, "freeze_first_timeout");
      ena = 1'b0;
      for (int t = 0; t < 10; t++) begin
         check("freeze_valid", 32'(bus.o_valid), 32'd1);
         check("freeze_id", 32'(bus.o_packet_id), 32'(exp_q[0][7:0]));
         check("freeze_cnt", 32'(dut.cnt_r), 32'd253);
         check("freeze_rem", 32'(dut.rem_r), 32'd1);
         tick();
      end
      ena = 1'b1;
      wait_acc(n_acc + 1, 5, "resume_pkt_timeout");
      for (int p = 0; p < 2; p++) begin
         wait_acc(n_acc + 1, 5, "resume_pkt_timeout");
         check("resume_b2b", 32'(last_acc - prev_acc), 32'd1);
      end
      repeat (5) tick();
      check("burst_exact_count", 32'(n_acc - n_mark), 32'd4);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      ch_en = 4'b0000;
      tick();

      // Drop counter saturation under permanent backpressure
      bus.i_ready = 1'b0;
      ch_en       = 4'b0101;
      model_slot(4'b0101, 1'b1);
      wait_valid(300, "sat_valid_timeout");
      for (int b = 0; b < 20000 && bus.o_drop_cnt != 8'hFF; b++) tick();
      check("drop_reach_255", 32'(bus.o_drop_cnt), 32'd255);
      repeat (600) tick();
      check("drop_saturated", 32'(bus.o_drop_cnt), 32'd255);
      check("sat_hold_id", 32'(bus.o_packet_id), 32'(exp_q[0][7:0]));

      // Asynchronous reset in the middle of a burst with a pending packet
      for (int b = 0; b < 300 && dut.state_r != ST_BURST; b++) tick();
      check("pre_rst_burst", 32'(dut.state_r == ST_BURST), 32'd1);
      check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.o_valid), 32'd0);
      check("arst_id", 32'(bus.o_packet_id), 32'd0);
      check("arst_ch", 32'(bus.o_ch), 32'd0);
      check("arst_drop", 32'(bus.o_drop_cnt), 32'd0);
      check("arst_cnt", 32'(dut.cnt_r), 32'd0);
      check("arst_state", 32'(dut.state_r == ST_IDLE), 32'd1);
      check("arst_rr", 32'(dut.rr_r), 32'd0);
      model_reset();
      check_lfsrs("arst_lfsr");
      tick();
      bus.i_ready = 1'b1;
      ch_en       = 4'b0011;
      burst       = 2'd0;
      rst_n       = 1'b1;
      model_slot(4'b0011, 1'b1);
      wait_acc(n_acc + 1, 10, "post_rst_pkt_timeout");
      check("post_rst_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
